asymmetric_pulse_gen: RTL and testbench
=======================================

ASYMMETRIC_PULSE_GEN -- requirements
Module: asymmetric_pulse_gen

Interface
REQ-001 Parameter CLK_HZ, default 40_000_000, SHALL set the clock frequency in Hz and the accumulator modulus.
REQ-002 Port clk  input  1  SHALL be the single system clock, nominal 40 MHz (25 ns period).
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
REQ-004 Port speed  input  8  SHALL be the requested pulse rate in pulses per second; 0 means stopped.
REQ-005 Port duty  input  4  SHALL be the high-time fraction in sixteenths of the period; valid range 0..15.
REQ-006 Port pulse  output  1  SHALL be the emulated motor tach pulse train (registered).
REQ-007 Port period_tick  output  1  SHALL be a one-clk strobe marking each period boundary.

Function
REQ-008 The block SHALL hold registers speed_q (8 b), duty_q (4 b), and acc (26 b, modulus CLK_HZ).
REQ-009 Idle (speed_q == 0): acc SHALL be held at 0, pulse = 0, and speed/duty SHALL be sampled into speed_q/duty_q every clk.
REQ-010 Running (speed_q != 0): each clk, sum = acc + speed_q; if sum >= CLK_HZ then acc <= sum - CLK_HZ, otherwise acc <= sum.
REQ-011 A wrap (sum >= CLK_HZ) SHALL assert period_tick for exactly that one clk and SHALL resample speed/duty into speed_q/duty_q.
REQ-012 speed/duty changes SHALL NOT take effect mid-period; they apply only at a wrap or while idle.
REQ-013 thr SHALL equal duty_q * (CLK_HZ/16), computed by constant multiply with no divider.
REQ-014 pulse SHALL be registered as (speed_q != 0) && (acc < thr), so pulse has one clk of latency from acc.
REQ-015 Mean period SHALL be CLK_HZ/speed clks. For non-integer ratios, individual periods SHALL differ by at most 1 clk, with no long-term drift.
REQ-016 duty_q = 0 SHALL give pulse constantly 0 while running, with period_tick still strobing.
REQ-017 Maximum high fraction SHALL be 15/16. Each period SHALL start high, provided duty_q > 0.
REQ-018 Going from running to a sampled speed of 0 at a wrap SHALL force pulse low the next clk. No further period_tick SHALL occur.
REQ-019 Going from idle to nonzero speed SHALL start the period with acc = 0, so pulse rises 1 clk after sampling.
REQ-020 The adder SHALL be sized so it cannot overflow: acc + 255 < 2^26 for CLK_HZ <= 60_000_000.

Reset
REQ-021 Asserting reset low SHALL asynchronously clear acc, speed_q, duty_q, pulse and period_tick to 0.
REQ-022 Reset asserted mid-period SHALL drop pulse to 0 immediately, without waiting for clk.
REQ-023 After reset release, the block SHALL enter idle and sample on the first clk edge.

Structure
REQ-024 A shared package SHALL define CLK_HZ default, DUTY_STEP = CLK_HZ/16, ACC_W = 26 and SPEED_W = 8.
REQ-025 A single sub-module, pulse_nco (the accumulator with wrap and tick), is natural. Duty compare and the pulse register SHALL stay in the top module.
REQ-026 The design SHALL have no divider, no multicycle paths and no latches.
REQ-027 The RTL SHALL be synthesizable and SHALL close timing at 40 MHz.

Verification
REQ-028 speed=100, duty=8 -> period 400,000 clk (10 ms); high 200,000 clk; one period_tick per period.
REQ-029 speed=50, duty=4 -> period 800,000 clk; high 200,000 clk (5 ms) and low 600,000 clk (15 ms).
REQ-030 speed=255, duty=8 for 255 periods -> each period 156,862 or 156,863 clk; total exactly 40,000,000 clk.
REQ-031 Change speed 100 -> 200 at mid-high -> current period completes at 400,000 clk; next period is 200,000 clk.
REQ-032 speed=0 from a wrap onward -> pulse low and no period_tick for 1,000,000 clk; then speed=25 -> pulse rises 2 clk later.
REQ-033 Reset pulled low mid-high -> pulse=0 and period_tick=0 asynchronously; acc reads 0 after release.

Source files
------------

// File: rtl/asymmetric_pulse_gen_pkg.sv
// Shared constants for the tach pulse emulator: clock modulus, accumulator
// and input widths.
package asymmetric_pulse_gen_pkg;

    localparam int CLK_HZ_DEFAULT = 40_000_000;
    localparam int DUTY_STEP      = CLK_HZ_DEFAULT / 16;
    localparam int ACC_W          = 26;
    localparam int SPEED_W        = 8;
    localparam int DUTY_W         = 4;

endpackage

// File: rtl/asymmetric_pulse_gen_nco.sv
// Phase accumulator: advances by speed_q each clk modulo CLK_HZ, strobes on
// wrap and latches new speed/duty only at a wrap or while stopped.
module pulse_nco
    import asymmetric_pulse_gen_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SPEED_W-1:0] speed,
    input  logic [DUTY_W-1:0]  duty,
    output logic [ACC_W-1:0]   acc,
    output logic [SPEED_W-1:0] speed_q,
    output logic [DUTY_W-1:0]  duty_q,
    output logic               period_tick
);

    localparam logic [ACC_W:0] MODULUS = (ACC_W + 1)'(CLK_HZ);

    // One spare bit so acc + speed_q can never wrap the adder itself.
    logic [ACC_W:0]   sum;
    logic             running;
    logic             wrap;
    logic [ACC_W-1:0] acc_next;

    always_comb begin
        running  = (speed_q != '0);
        sum      = {1'b0, acc} + (ACC_W + 1)'(speed_q);
        wrap     = running && (sum >= MODULUS);
        acc_next = '0;
        if (wrap) begin
            acc_next = ACC_W'(sum - MODULUS);
        end else if (running) begin
            acc_next = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            speed_q     <= '0;
            duty_q      <= '0;
            period_tick <= 1'b0;
        end else begin
            acc         <= acc_next;
            period_tick <= wrap;
            if (!running || wrap) begin
                speed_q <= speed;
                duty_q  <= duty;
            end
        end
    end

endmodule

// File: rtl/asymmetric_pulse_gen.sv
// Emulated motor tach: a pulse train at 'speed' pulses/s whose high time is
// duty/16 of each period, plus a one-clk strobe at every period boundary.
module asymmetric_pulse_gen
    import asymmetric_pulse_gen_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] speed,
    input  logic [DUTY_W-1:0]  duty,
    output logic               pulse,
    output logic               period_tick
);

    localparam logic [ACC_W-1:0] THR_STEP = ACC_W'(CLK_HZ / 16);

    logic [ACC_W-1:0]   acc;
    logic [SPEED_W-1:0] speed_q;
    logic [DUTY_W-1:0]  duty_q;
    logic [ACC_W-1:0]   thr;

    pulse_nco #(
        .CLK_HZ(CLK_HZ)
    ) u_nco (
        .clk         (clk),
        .rst_n       (reset),
        .speed       (speed),
        .duty        (duty),
        .acc         (acc),
        .speed_q     (speed_q),
        .duty_q      (duty_q),
        .period_tick (period_tick)
    );

    // Constant multiplier: duty_q is only 4 bits, so this is a few adders.
    assign thr = ACC_W'(duty_q) * THR_STEP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse <= 1'b0;
        end else begin
            pulse <= (speed_q != '0) && (acc < thr);
        end
    end

endmodule

// File: tb/tb_asymmetric_pulse_gen.sv
// Scoreboard bench: stimulus pushes per-period (length, high time) expectations
// from a closed-form model; a monitor measures each period at period_tick.
module tb_asymmetric_pulse_gen;

    localparam int CLK_HZ = 1600;
    localparam int STEP   = CLK_HZ / 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] speed = 8'd0;
    logic [3:0] duty = 4'd0;
    logic       pulse;
    logic       period_tick;

    asymmetric_pulse_gen #(.CLK_HZ(CLK_HZ)) dut (
        .clk         (clk),
        .reset       (reset),
        .speed       (speed),
        .duty        (duty),
        .pulse       (pulse),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int high;
        int spd;
        int dty;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   residue = 0;
    bit   mon_start = 1'b0;

    // Period k starts at phase 'residue' (fraction of a period in units of
    // 1/CLK_HZ); it lasts until phase reaches a full turn and is high while
    // phase is below duty/16 of a turn.
    function automatic exp_t model_period(input int s, input int d);
        exp_t e;
        int   thr;
        thr    = d * STEP;
        e.spd  = s;
        e.dty  = d;
        e.len  = (CLK_HZ - residue + s - 1) / s;
        e.high = (residue < thr) ? (thr - residue + s - 1) / s : 0;
        residue = residue + e.len * s - CLK_HZ;
        return e;
    endfunction

    // Monitor
    initial begin : monitor
        exp_t e;
        bit   armed;
        int   cyc_cnt;
        int   high_cnt;
        int   pnum;
        armed = 1'b0; cyc_cnt = 0; high_cnt = 0; pnum = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                armed = 1'b0;
            end else if (mon_start) begin
                mon_start = 1'b0;
                armed = 1'b1;
                cyc_cnt = 0;
                high_cnt = 0;
            end else if (armed) begin
                cyc_cnt++;
                if (pulse) high_cnt++;
                if (period_tick) begin
                    pnum++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_tick period %0d len %0d", pnum, cyc_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        checks += 2;
                        $display("period %0d speed %0d duty %0d len %0d/%0d high %0d/%0d",
                                 pnum, e.spd, e.dty, cyc_cnt, e.len, high_cnt, e.high);
                        if (cyc_cnt != e.len) begin
                            errors++;
                            $display("FAIL period_len got %0d expected %0d", cyc_cnt, e.len);
                        end
                        if (high_cnt != e.high) begin
                            errors++;
                            $display("FAIL high_time got %0d expected %0d", high_cnt, e.high);
                        end
                    end
                    cyc_cnt = 0;
                    high_cnt = 0;
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0b expected %0b", name, got, want);
        end else begin
            $display("check %s = %0b", name, got);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * CLK_HZ; i++) begin
            @(negedge clk);
            if (period_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL tick_timeout got none expected a period_tick");
        end
    endtask

    // Start from idle (or release reset on the sampling edge) with s1/d1; s2/d2
    // is applied mid-period 1 and must only govern period 2.
    task automatic launch(input int s1, input int d1, input int s2, input int d2,
                          input bit release_rst);
        @(negedge clk);
        if (release_rst) reset = 1'b1;
        speed = 8'(s1);
        duty  = 4'(d1);
        residue = 0;
        exp_q.push_back(model_period(s1, d1));
        @(posedge clk);
        #1;
        mon_start = 1'b1;
        speed = 8'(s2);
        duty  = 4'(d2);
        exp_q.push_back(model_period(s2, d2));
        @(negedge clk);
        check_bit("rise_not_early", pulse, 1'b0);
        @(negedge clk);
        check_bit("rise_after_2clk", pulse, logic'(d1 != 0));
    endtask

    task automatic run_periods(input int n, input bit directed);
        bit ok;
        int s;
        int d;
        int tbl_s[8] = '{100, 50, 255, 255, 255, 7, 9, 1};
        int tbl_d[8] = '{8, 4, 8, 8, 8, 0, 15, 15};
        for (int k = 0; k < n; k++) begin
            wait_tick(ok);
            if (!ok) return;
            if (directed && k < 8) begin
                s = tbl_s[k];
                d = tbl_d[k];
            end else begin
                s = int'($urandom_range(1, 255));
                d = int'($urandom_range(0, 15));
            end
            speed = 8'(s);
            duty  = 4'(d);
            exp_q.push_back(model_period(s, d));
        end
    endtask

    task automatic stop_and_check();
        bit ok;
        int ticks;
        int highs;
        wait_tick(ok);
        speed = 8'd0;
        duty  = 4'(int'($urandom_range(0, 15)));
        wait_tick(ok);
        ticks = 0;
        highs = 0;
        for (int i = 0; i < 3 * CLK_HZ; i++) begin
            @(negedge clk);
            if (period_tick) ticks++;
            if (pulse) highs++;
        end
        checks += 3;
        $display("stopped window ticks %0d highs %0d pending %0d", ticks, highs, exp_q.size());
        if (ticks != 0) begin
            errors++;
            $display("FAIL stop_ticks got %0d expected 0", ticks);
        end
        if (highs != 0) begin
            errors++;
            $display("FAIL stop_pulse got %0d expected 0", highs);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained got %0d expected 0", exp_q.size());
        end
    endtask

    initial begin : stimulus
        bit ok;
        #1;
        check_bit("reset_pulse", pulse, 1'b0);
        check_bit("reset_tick", period_tick, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_bit("idle_pulse", pulse, 1'b0);

        launch(100, 8, 100, 8, 1'b0);
        run_periods(30, 1'b1);
        stop_and_check();

        launch(25, int'($urandom_range(1, 15)), 200, 8, 1'b0);
        run_periods(20, 1'b0);
        stop_and_check();

        // Asynchronous reset in the high phase of a period
        launch(25, 8, 25, 8, 1'b0);
        wait_tick(ok);
        @(negedge clk);
        @(negedge clk);
        check_bit("pre_reset_high", pulse, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_bit("async_reset_pulse", pulse, 1'b0);
        check_bit("async_reset_tick", period_tick, 1'b0);
        exp_q.delete();
        speed = 8'd0;
        repeat (3) @(negedge clk);
        launch(int'($urandom_range(1, 255)), int'($urandom_range(1, 15)),
               int'($urandom_range(1, 255)), int'($urandom_range(0, 15)), 1'b1);
        run_periods(10, 1'b0);
        stop_and_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
